// File: rtl/resp_compactor_pkg.sv
// Shared constants and FSM encoding for the response compactor.
package resp_compactor_pkg;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;
    // x^32 + x^22 + x^2 + x + 1 (the x^32 term is implicit in the shift-out)
    localparam logic [31:0] POLY = 32'h0040_0007;

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
endpackage

// File: rtl/resp_compactor_if.sv
// Control, response-stream and status signals of the response compactor.
interface resp_compactor_if #(
    parameter int OUT_W = 21,
    parameter int SIG_W = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic [SIG_W-1:0] exp_sig;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] f;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] vec_cnt;
    logic             nonuni;

    modport master (
        output start, num_vec, exp_sig, in_valid, f,
        input  in_ready, busy, done, pass, sig, vec_cnt, nonuni
    );

    modport slave (
        input  start, num_vec, exp_sig, in_valid, f,
        output in_ready, busy, done, pass, sig, vec_cnt, nonuni
    );
endinterface

// File: rtl/resp_compactor_misr_step.sv
// One MISR step: Galois shift of the signature, then fold in the zero-extended response.
module misr_step
    import resp_compactor_pkg::*;
#(
    parameter int OUT_W = 21,
    parameter int SIG_W = 32
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [OUT_W-1:0] f,
    output logic [SIG_W-1:0] next_sig
);
    localparam logic [SIG_W-1:0] POLY_W = SIG_W'(POLY);

    assign next_sig = {sig[SIG_W-2:0], 1'b0}
                    ^ (sig[SIG_W-1] ? POLY_W : '0)
                    ^ SIG_W'(f);
endmodule

// File: rtl/resp_compactor.sv
// Compacts a stream of response vectors into a MISR signature and compares it to a golden value.
module resp_compactor
    import resp_compactor_pkg::*;
#(
    parameter int OUT_W = 21,
    parameter int SIG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    resp_compactor_if.slave  bus
);
    localparam logic [SIG_W-1:0] SEED_W = SIG_W'(SEED);

    state_t           state, state_nxt;
    logic [SIG_W-1:0] sig_q, sig_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_inc, num_q;
    logic             pass_q, nonuni_q;
    logic             load, accept, last;

    misr_step #(.OUT_W(OUT_W), .SIG_W(SIG_W)) u_step (
        .sig      (sig_q),
        .f        (bus.f),
        .next_sig (sig_nxt)
    );

    assign load    = ((state == IDLE) || (state == DONE)) && bus.start;
    assign accept  = (state == RUN) && bus.in_valid;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign last    = (cnt_inc == num_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = (bus.num_vec != '0) ? RUN : CHECK;
            RUN:        if (accept && last) state_nxt = CHECK;
            CHECK:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Results stay frozen through DONE until the next accepted start reloads them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q    <= SEED_W;
            cnt_q    <= '0;
            num_q    <= '0;
            pass_q   <= 1'b0;
            nonuni_q <= 1'b0;
        end else begin
            if (load) begin
                sig_q    <= SEED_W;
                cnt_q    <= '0;
                num_q    <= bus.num_vec;
                pass_q   <= 1'b0;
                nonuni_q <= 1'b0;
            end else if (accept) begin
                sig_q    <= sig_nxt;
                cnt_q    <= cnt_inc;
                nonuni_q <= nonuni_q | ((bus.f != '0) && (bus.f != '1));
            end
            if (state == CHECK) pass_q <= (sig_q == bus.exp_sig);
        end
    end

    assign bus.in_ready = (state == RUN);
    assign bus.busy     = (state == RUN) || (state == CHECK);
    assign bus.done     = (state == DONE);
    assign bus.pass     = pass_q;
    assign bus.sig      = sig_q;
    assign bus.vec_cnt  = cnt_q;
    assign bus.nonuni   = nonuni_q;
endmodule

// File: tb/tb_resp_compactor.sv
// Randomized bench for resp_compactor against a polynomial-arithmetic signature model.
module tb_resp_compactor;
    localparam int OUT_W = 21;
    localparam int SIG_W = 32;
    localparam int CNT_W = 16;
    localparam logic [31:0] SEED_V = 32'hFFFF_FFFF;
    localparam logic [20:0] ONES_F = 21'h1F_FFFF;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [20:0] fq[$];
    bit          vq[$];

    resp_compactor_if #(.OUT_W(OUT_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) bus();

    resp_compactor #(.OUT_W(OUT_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Multiply by x modulo the degree-32 polynomial, then add the response.
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [20:0] fv);
        logic [63:0] t;
        t = {32'b0, s} * 64'd2;
        if (t >= 64'h1_0000_0000) t = t ^ 64'h1_0040_0007;
        return t[31:0] ^ {11'b0, fv};
    endfunction

    function automatic logic [20:0] rnd_f();
        case ($urandom_range(0, 3))
            0:       return 21'h0;
            1:       return ONES_F;
            default: return 21'($urandom);
        endcase
    endfunction

    task automatic run_vec(input int n, input logic [31:0] exp_v, input bit exp_from_model,
                           input string tag, output logic [31:0] sig_out);
        logic [31:0] msig;
        logic [31:0] e;
        logic [20:0] fv;
        int          cnt;
        int          budget;
        bit          nu;
        bit          v;
        msig = SEED_V; cnt = 0; budget = 0; nu = 0;
        bus.start = 1'b1; bus.num_vec = 16'(n); bus.exp_sig = exp_v;
        tick();
        bus.start = 1'b0;
        chk({tag, ":start_busy"},   64'(bus.busy),    64'd1);
        chk({tag, ":start_sig"},    64'(bus.sig),     64'(SEED_V));
        chk({tag, ":start_cnt"},    64'(bus.vec_cnt), 64'd0);
        chk({tag, ":start_nonuni"}, 64'(bus.nonuni),  64'd0);
        chk({tag, ":start_pass"},   64'(bus.pass),    64'd0);
        while (cnt < n && budget < 400) begin
            chk({tag, ":ready_run"}, 64'(bus.in_ready), 64'd1);
            v  = (vq.size() != 0) ? vq.pop_front() : 1'($urandom_range(0, 1));
            fv = (v && fq.size() != 0) ? fq.pop_front() : rnd_f();
            bus.in_valid = v; bus.f = fv;
            tick();
            if (v) begin
                msig = ref_step(msig, fv);
                cnt++;
                if (fv != 21'h0 && fv != ONES_F) nu = 1;
            end
            budget++;
        end
        if (cnt < n) chk({tag, ":budget"}, 64'(cnt), 64'(n));
        bus.in_valid = 1'($urandom_range(0, 1)); bus.f = rnd_f();
        e = exp_from_model ? msig : exp_v;
        bus.exp_sig = e;
        chk({tag, ":chk_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, ":chk_busy"},  64'(bus.busy),     64'd1);
        chk({tag, ":chk_done"},  64'(bus.done),     64'd0);
        chk({tag, ":chk_sig"},   64'(bus.sig),      64'(msig));
        chk({tag, ":chk_cnt"},   64'(bus.vec_cnt),  64'(n));
        tick();
        chk({tag, ":done"},      64'(bus.done),     64'd1);
        chk({tag, ":done_busy"}, 64'(bus.busy),     64'd0);
        chk({tag, ":done_rdy"},  64'(bus.in_ready), 64'd0);
        chk({tag, ":pass"},      64'(bus.pass),     64'(msig == e));
        chk({tag, ":sig"},       64'(bus.sig),      64'(msig));
        chk({tag, ":cnt"},       64'(bus.vec_cnt),  64'(n));
        chk({tag, ":nonuni"},    64'(bus.nonuni),   64'(nu));
        bus.in_valid = 1'b1; bus.f = rnd_f();
        tick();
        chk({tag, ":hold_sig"},  64'(bus.sig),      64'(msig));
        chk({tag, ":hold_cnt"},  64'(bus.vec_cnt),  64'(n));
        chk({tag, ":hold_done"}, 64'(bus.done),     64'd1);
        chk({tag, ":hold_pass"}, 64'(bus.pass),     64'(msig == e));
        bus.in_valid = 1'b0;
        sig_out = msig;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":ready"},  64'(bus.in_ready), 64'd0);
        chk({tag, ":busy"},   64'(bus.busy),     64'd0);
        chk({tag, ":done"},   64'(bus.done),     64'd0);
        chk({tag, ":pass"},   64'(bus.pass),     64'd0);
        chk({tag, ":nonuni"}, 64'(bus.nonuni),   64'd0);
        chk({tag, ":sig"},    64'(bus.sig),      64'(SEED_V));
        chk({tag, ":cnt"},    64'(bus.vec_cnt),  64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] s;
        logic [31:0] msig;
        logic [20:0] fv;
        rst = 1'b1;
        bus.start = 1'b0; bus.num_vec = '0; bus.exp_sig = '0;
        bus.in_valid = 1'b0; bus.f = '0;
        tick(); tick();
        chk_reset_vals("por");
        rst = 1'b0;
        tick();
        chk_reset_vals("idle");

        fq.push_back(21'h0);
        run_vec(1, 32'hFFBF_FFF9, 0, "zero_vec", s);
        chk("zero_vec:const_sig",  64'(bus.sig),  64'h0000_0000_FFBF_FFF9);
        chk("zero_vec:const_pass", 64'(bus.pass), 64'd1);

        fq.push_back(ONES_F);
        run_vec(1, 32'hFFA0_0006, 0, "ones_vec", s);
        chk("ones_vec:const_pass", 64'(bus.pass), 64'd1);
        fq.push_back(ONES_F);
        run_vec(1, 32'h0, 0, "ones_bad", s);
        chk("ones_bad:const_pass", 64'(bus.pass), 64'd0);

        vq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        run_vec(3, 32'h0, 1, "toggle", s);

        fq.push_back(21'h000001);
        run_vec(1, 32'h0, 1, "single_bit", s);
        chk("single_bit:const_nonuni", 64'(bus.nonuni), 64'd1);

        run_vec(0, 32'hFFFF_FFFF, 0, "empty", s);
        chk("empty:const_pass", 64'(bus.pass), 64'd1);

        for (int i = 0; i < 8; i++)
            run_vec($urandom_range(1, 40), $urandom, ($urandom_range(0, 1) == 1), $sformatf("rnd%0d", i), s);

        // Partial run: a start during RUN must not reload; reset abandons the run.
        bus.start = 1'b1; bus.num_vec = 16'd5; bus.exp_sig = '0;
        tick();
        bus.start = 1'b0;
        msig = SEED_V;
        fv = 21'h000001;
        bus.in_valid = 1'b1; bus.f = fv;
        tick();
        msig = ref_step(msig, fv);
        fv = rnd_f();
        bus.start = 1'b1; bus.num_vec = 16'd1; bus.f = fv;
        tick();
        msig = ref_step(msig, fv);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        chk("midrun:cnt",    64'(bus.vec_cnt),  64'd2);
        chk("midrun:sig",    64'(bus.sig),      64'(msig));
        chk("midrun:ready",  64'(bus.in_ready), 64'd1);
        chk("midrun:nonuni", 64'(bus.nonuni),   64'd1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        tick();
        rst = 1'b0;
        tick();
        chk_reset_vals("post_rst");
        run_vec(5, 32'h0, 1, "rerun", s);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
